rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between two write-back requesters.
  - Port 0: main pipeline write-back.
  - Port 1: long-latency unit (divider/load).
- Tracks outstanding long-latency destinations in a 32-entry busy scoreboard, so decode can stall on hazards.
- Sits between write-back sources and the register file.
- Drives rf write signals from a registered stage; writes land one cycle after the handshake.

---
 rtl/rf_wb_arbiter_if.sv | 49 ++++
 rtl/rf_wb_arbiter.sv | 88 ++++++++
 tb/tb_rf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus bundle for rf_wb_arbiter: two requester ports, issue/query
// scoreboard signals and the register-file write port.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              p0_valid;
    logic [4:0]        p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ready;

    logic              p1_valid;
    logic [4:0]        p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;

    logic              issue_valid;
    logic [4:0]        issue_rd;

    logic [4:0]        q_a1;
    logic [4:0]        q_a2;
    logic              q_busy1;
    logic              q_busy2;

    logic              rf_we3;
    logic [4:0]        rf_a3;
    logic [DATA_W-1:0] rf_wd3;

    modport slave (
        input  p0_valid, p0_rd, p0_data,
        output p0_ready,
        input  p1_valid, p1_rd, p1_data,
        output p1_ready,
        input  issue_valid, issue_rd,
        input  q_a1, q_a2,
        output q_busy1, q_busy2,
        output rf_we3, rf_a3, rf_wd3
    );

    modport master (
        output p0_valid, p0_rd, p0_data,
        input  p0_ready,
        output p1_valid, p1_rd, p1_data,
        input  p1_ready,
        output issue_valid, issue_rd,
        output q_a1, q_a2,
        input  q_busy1, q_busy2,
        input  rf_we3, rf_a3, rf_wd3
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between the main pipeline
// (port 0) and a long-latency unit (port 1), with a busy scoreboard for decode.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic          clk,
    input logic          reset_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREG  = 32;

    logic [CNT_W-1:0]  wait_q,   wait_d;
    logic [NREG-1:0]   busy_q,   busy_d;
    logic              rf_we3_q, rf_we3_d;
    logic [4:0]        rf_a3_q,  rf_a3_d;
    logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;

    logic force1;
    logic p0_xfer;
    logic p1_xfer;

    // Port 0 has priority until port 1 has been starved for MAX_WAIT cycles.
    assign force1       = (wait_q == CNT_W'(MAX_WAIT));
    assign bus.p0_ready = !(force1 & bus.p1_valid);
    assign bus.p1_ready = !bus.p0_valid | force1;
    assign p0_xfer      = bus.p0_valid & bus.p0_ready;
    assign p1_xfer      = bus.p1_valid & bus.p1_ready;

    // Next-state for the starvation counter, write stage and scoreboard.
    always_comb begin
        wait_d   = '0;
        rf_we3_d = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        busy_d   = busy_q;

        if (bus.p1_valid && !bus.p1_ready) begin
            wait_d = (wait_q < CNT_W'(MAX_WAIT)) ? wait_q + CNT_W'(1) : wait_q;
        end

        if (p0_xfer) begin
            rf_we3_d = (bus.p0_rd != 5'd0);
            rf_a3_d  = bus.p0_rd;
            rf_wd3_d = bus.p0_data;
        end else if (p1_xfer) begin
            rf_we3_d = (bus.p1_rd != 5'd0);
            rf_a3_d  = bus.p1_rd;
            rf_wd3_d = bus.p1_data;
        end

        // Clear before set so a same-cycle issue to the same register wins.
        if (p1_xfer) begin
            busy_d[bus.p1_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q   <= '0;
            busy_q   <= '0;
            rf_we3_q <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
        end else begin
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            rf_we3_q <= rf_we3_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
        end
    end

    assign bus.rf_we3 = rf_we3_q;
    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_wd3 = rf_wd3_q;

    // A register stays busy through its in-flight write-stage cycle.
    assign bus.q_busy1 = (bus.q_a1 != 5'd0) &
                         (busy_q[bus.q_a1] | (rf_we3_q & (rf_a3_q == bus.q_a1)));
    assign bus.q_busy2 = (bus.q_a2 != 5'd0) &
                         (busy_q[bus.q_a2] | (rf_we3_q & (rf_a3_q == bus.q_a2)));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: reset, single writes,
// contention/starvation, scoreboard set/clear, x0 writes and mid-write reset.
module tb_rf_wb_arbiter;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.p0_valid    = 1'b0;
        bus.p0_rd       = 5'd0;
        bus.p0_data     = '0;
        bus.p1_valid    = 1'b0;
        bus.p1_rd       = 5'd0;
        bus.p1_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.q_a1        = 5'd0;
        bus.q_a2        = 5'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we3 !== 1'b0 || bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf: we=%b a3=%0d wd=%h, want 0/0/0", bus.rf_we3, bus.rf_a3, bus.rf_wd3);
        end
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: p0=%b p1=%b, want 1/1", bus.p0_ready, bus.p1_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int q = 0; q < 32; q++) begin
            bus.q_a1 = 5'(q);
            bus.q_a2 = 5'(31 - q);
            #1;
            checks++;
            if (bus.q_busy1 !== 1'b0 || bus.q_busy2 !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy q=%0d: busy1=%b busy2=%b, want 0/0", q, bus.q_busy1, bus.q_busy2);
            end
        end
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: p0=%b p1=%b, want 1/1", bus.p0_ready, bus.p1_ready);
        end
    endtask

    task automatic test_single_p0();
        @(negedge clk);
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd5;
        bus.p0_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.p0_ready !== 1'b1) begin
            errors++;
            $display("FAIL p0_ready: got %b want 1", bus.p0_ready);
        end
        @(negedge clk);
        bus.p0_valid = 1'b0;
        checks++;
        if (bus.rf_we3 !== 1'b1 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_write: we=%b a3=%0d wd=%h, want 1/5/deadbeef", bus.rf_we3, bus.rf_a3, bus.rf_wd3);
        end
        @(negedge clk);
        checks++;
        if (bus.rf_we3 !== 1'b0 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_after: we=%b a3=%0d wd=%h, want 0/5/deadbeef (held)", bus.rf_we3, bus.rf_a3, bus.rf_wd3);
        end
    endtask

    task automatic test_contention();
        logic exp_p1;
        @(negedge clk);
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd2;
        bus.p0_data  = 32'h0000_0022;
        bus.p1_valid = 1'b1;
        bus.p1_rd    = 5'd7;
        bus.p1_data  = 32'h0000_0077;
        for (int c = 0; c < 7; c++) begin
            exp_p1 = (c == 4);
            #1;
            checks++;
            if (bus.p0_ready !== !exp_p1 || bus.p1_ready !== exp_p1) begin
                errors++;
                $display("FAIL contend_ready c=%0d: p0=%b p1=%b, want %b/%b", c, bus.p0_ready, bus.p1_ready, !exp_p1, exp_p1);
            end
            @(negedge clk);
            checks++;
            if (bus.rf_we3 !== 1'b1 || bus.rf_a3 !== (exp_p1 ? 5'd7 : 5'd2)
                || bus.rf_wd3 !== (exp_p1 ? 32'h77 : 32'h22)) begin
                errors++;
                $display("FAIL contend_write c=%0d: we=%b a3=%0d wd=%h, want 1/%0d", c, bus.rf_we3, bus.rf_a3, bus.rf_wd3, exp_p1 ? 7 : 2);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.q_a1        = 5'd9;
        bus.q_a2        = 5'd9;
        #1;
        checks++;
        if (bus.q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_before_set: busy1=%b want 0", bus.q_busy1);
        end
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.p1_valid    = 1'b1;
        bus.p1_rd       = 5'd9;
        bus.p1_data     = 32'h0000_0099;
        #1;
        checks++;
        if (bus.q_busy1 !== 1'b1 || bus.q_busy2 !== 1'b1 || bus.p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_set: busy1=%b busy2=%b p1_ready=%b, want 1/1/1", bus.q_busy1, bus.q_busy2, bus.p1_ready);
        end
        @(negedge clk);
        bus.p1_valid = 1'b0;
        #1;
        checks++;
        if (bus.rf_we3 !== 1'b1 || bus.rf_a3 !== 5'd9 || bus.q_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_inflight: we=%b a3=%0d busy1=%b, want 1/9/1", bus.rf_we3, bus.rf_a3, bus.q_busy1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.q_busy1 !== 1'b0 || bus.q_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: busy1=%b busy2=%b, want 0/0", bus.q_busy1, bus.q_busy2);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.p1_valid    = 1'b1;
        bus.p1_rd       = 5'd3;
        bus.p1_data     = 32'h0000_0333;
        bus.q_a1        = 5'd3;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.p1_valid    = 1'b0;
        checks++;
        if (bus.rf_we3 !== 1'b1 || bus.rf_a3 !== 5'd3 || bus.rf_wd3 !== 32'h333) begin
            errors++;
            $display("FAIL setwins_write: we=%b a3=%0d wd=%h, want 1/3/333", bus.rf_we3, bus.rf_a3, bus.rf_wd3);
        end
        @(negedge clk);
        checks++;
        if (bus.rf_we3 !== 1'b0 || bus.q_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL setwins_busy: we=%b busy1=%b, want 0/1", bus.rf_we3, bus.q_busy1);
        end
        bus.p1_valid = 1'b1;
        @(negedge clk);
        bus.p1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL setwins_clear: busy1=%b want 0", bus.q_busy1);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.p1_valid    = 1'b1;
        bus.p1_rd       = 5'd0;
        bus.p1_data     = 32'h0000_005A;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.q_a1        = 5'd0;
        #1;
        checks++;
        if (bus.p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b want 1", bus.p1_ready);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.rf_we3 !== 1'b0 || bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'h5A) begin
            errors++;
            $display("FAIL x0_write: we=%b a3=%0d wd=%h, want 0/0/5a", bus.rf_we3, bus.rf_a3, bus.rf_wd3);
        end
        checks++;
        if (bus.q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: busy1=%b want 0", bus.q_busy1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.p0_valid    = 1'b1;
        bus.p0_rd       = 5'd4;
        bus.p0_data     = 32'h0000_0044;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        bus.q_a1        = 5'd12;
        bus.q_a2        = 5'd4;
        @(negedge clk);
        idle_inputs();
        bus.q_a1 = 5'd12;
        bus.q_a2 = 5'd4;
        #1;
        checks++;
        if (bus.rf_we3 !== 1'b1 || bus.q_busy1 !== 1'b1 || bus.q_busy2 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: we=%b busy1=%b busy2=%b, want 1/1/1", bus.rf_we3, bus.q_busy1, bus.q_busy2);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_we3 !== 1'b0 || bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'd0
            || bus.q_busy1 !== 1'b0 || bus.q_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post: we=%b a3=%0d wd=%h busy1=%b busy2=%b, want all 0",
                     bus.rf_we3, bus.rf_a3, bus.rf_wd3, bus.q_busy1, bus.q_busy2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_p0();
        test_contention();
        test_scoreboard();
        test_set_wins();
        test_x0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
